four_12_12_st0_tap_mem: RTL and testbench

Tap memory responder for the stage-0 weight path: it accepts the tap-interface read and write commands issued by the stage-0 control logic and returns the 384-bit tap row (12 x float_24_8 lanes) with registered one-cycle read latency. It supports two kinds of write: whole-row writes (tap update from the stage datapath) and single-lane sub-word writes (error update). Read-during-write to the same row is write-first. Storage is flop-based and sits between the stage control and the stage datapath tap inputs.

---
 rtl/four_12_12_st0_tap_mem.sv | 109 ++++++++++
 tb/tb_four_12_12_st0_tap_mem.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/four_12_12_st0_tap_mem.sv
// Stage-0 tap memory: flop-based row store with whole-row and single-lane writes,
// one-cycle registered reads and write-first forwarding on same-row collisions.
module four_12_12_st0_tap_mem #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned LANES  = 12,
  parameter int unsigned LANE_W = 32
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [ADDR_W-1:0]         rd_address_i,
  input  logic                      rd_vld_i,
  input  logic [ADDR_W-1:0]         wr_address_i,
  input  logic                      wr_vld_i,
  input  logic [LANES*LANE_W-1:0]   wr_data_i,
  input  logic                      sub_vld_i,
  input  logic [31:0]               sub_addr_i,
  input  logic [LANE_W-1:0]         sub_data_i,
  output logic [LANES*LANE_W-1:0]   rd_data_o,
  output logic                      rd_data_vld_o,
  output logic                      sub_err_o
);

  localparam int unsigned RowW     = LANES * LANE_W;
  localparam int unsigned LaneIdxW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);
  localparam logic [31:0]     LanesW = 32'(LANES);

  logic [RowW-1:0] mem_q [DEPTH];
  logic [RowW-1:0] rd_data_q, rd_data_d;
  logic            rd_data_vld_q, rd_data_vld_d;
  logic            sub_err_q, sub_err_d;

  logic                wr_in_range, rd_in_range, sub_legal;
  logic                wr_en, err_set;
  logic [LaneIdxW-1:0] lane_idx;
  logic [RowW-1:0]     wr_row_old, wr_row, rd_row;

  assign wr_in_range = {1'b0, wr_address_i} < DepthW;
  assign rd_in_range = {1'b0, rd_address_i} < DepthW;
  assign sub_legal   = sub_addr_i < LanesW;
  assign lane_idx    = sub_addr_i[LaneIdxW-1:0];

  // Out-of-range rows are dropped silently; only an illegal lane raises the error.
  assign wr_en   = wr_vld_i & wr_in_range & (~sub_vld_i | sub_legal);
  assign err_set = wr_vld_i & sub_vld_i & ~sub_legal;

  always_comb begin
    wr_row_old = '0;
    if (wr_in_range) begin
      wr_row_old = mem_q[wr_address_i];
    end
  end

  // Sub-word writes merge the new lane into the current row contents.
  always_comb begin
    wr_row = wr_data_i;
    if (sub_vld_i) begin
      wr_row = wr_row_old;
      if (sub_legal) begin
        wr_row[int'(lane_idx)*LANE_W +: LANE_W] = sub_data_i;
      end
    end
  end

  always_comb begin
    rd_row = '0;
    if (rd_in_range) begin
      if (wr_en && (wr_address_i == rd_address_i)) begin
        rd_row = wr_row;
      end else begin
        rd_row = mem_q[rd_address_i];
      end
    end
  end

  always_comb begin
    rd_data_d     = rd_vld_i ? rd_row : rd_data_q;
    rd_data_vld_d = rd_vld_i;
    sub_err_d     = sub_err_q | err_set;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[wr_address_i] <= wr_row;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_data_q     <= '0;
      rd_data_vld_q <= 1'b0;
      sub_err_q     <= 1'b0;
    end else begin
      rd_data_q     <= rd_data_d;
      rd_data_vld_q <= rd_data_vld_d;
      sub_err_q     <= sub_err_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign rd_data_vld_o = rd_data_vld_q;
  assign sub_err_o     = sub_err_q;

endmodule

// File: tb/tb_four_12_12_st0_tap_mem.sv
// Randomized self-checking bench for the stage-0 tap memory against a lane-array model.
module tb_four_12_12_st0_tap_mem;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [4:0]   rd_address, wr_address;
  logic         rd_vld, wr_vld, sub_vld;
  logic [383:0] wr_data;
  logic [31:0]  sub_addr, sub_data;
  logic [383:0] rd_data;
  logic         rd_data_vld, sub_err;

  int total = 0;
  int bad   = 0;

  logic [31:0]  model [32][12];
  logic [383:0] exp_rd;
  logic         exp_vld, exp_err;

  always #5 clk = ~clk;

  four_12_12_st0_tap_mem dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .rd_address_i (rd_address),
    .rd_vld_i     (rd_vld),
    .wr_address_i (wr_address),
    .wr_vld_i     (wr_vld),
    .wr_data_i    (wr_data),
    .sub_vld_i    (sub_vld),
    .sub_addr_i   (sub_addr),
    .sub_data_i   (sub_data),
    .rd_data_o    (rd_data),
    .rd_data_vld_o(rd_data_vld),
    .sub_err_o    (sub_err)
  );

  task automatic check(input string tag, input logic [383:0] got, input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] row_of(input int r);
    logic [383:0] v;
    for (int k = 0; k < 12; k++) v[k*32 +: 32] = model[r][k];
    return v;
  endfunction

  function automatic logic [383:0] mk_row(input logic [31:0] base);
    logic [383:0] v;
    for (int k = 0; k < 12; k++) v[k*32 +: 32] = base + 32'(k);
    return v;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++)
      for (int k = 0; k < 12; k++) model[r][k] = '0;
    exp_rd  = '0;
    exp_vld = 1'b0;
    exp_err = 1'b0;
  endtask

  // One clock of stimulus; the model applies the write before the read (write-first).
  task automatic step(input logic rv, input logic [4:0] ra, input logic wv,
                      input logic [4:0] wa, input logic [383:0] wd, input logic sv,
                      input logic [31:0] sa, input logic [31:0] sd, input string tag);
    rd_vld = rv; rd_address = ra; wr_vld = wv; wr_address = wa;
    wr_data = wd; sub_vld = sv; sub_addr = sa; sub_data = sd;
    @(posedge clk);
    if (wv) begin
      if (!sv) begin
        for (int k = 0; k < 12; k++) model[wa][k] = wd[k*32 +: 32];
      end else if (sa < 32'd12) begin
        model[wa][sa] = sd;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (rv) exp_rd = row_of(int'(ra));
    exp_vld = rv;
    #1;
    check({tag, ".data"}, rd_data, exp_rd);
    check({tag, ".vld"}, {383'b0, rd_data_vld}, {383'b0, exp_vld});
    check({tag, ".err"}, {383'b0, sub_err}, {383'b0, exp_err});
  endtask

  task automatic idle(input string tag);
    step(1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, '0, '0, tag);
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1;
    model_clear();
    check("rst.data", rd_data, '0);
    check("rst.vld", {383'b0, rd_data_vld}, '0);
    check("rst.err", {383'b0, sub_err}, '0);
    @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    rd_vld = 0; rd_address = 0; wr_vld = 0; wr_address = 0;
    wr_data = '0; sub_vld = 0; sub_addr = 0; sub_data = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("init.data", rd_data, '0);
    check("init.vld", {383'b0, rd_data_vld}, '0);
    #2 reset_n = 1'b1;

    step(1'b1, 5'd5, 1'b0, 5'd0, '0, 1'b0, '0, '0, "rd5");

    // Full write then read, and an unwritten neighbour.
    step(1'b0, 5'd0, 1'b1, 5'd12, mk_row(32'h3F80_0000), 1'b0, '0, '0, "wr12");
    step(1'b1, 5'd12, 1'b0, 5'd0, '0, 1'b0, '0, '0, "rd12");
    step(1'b1, 5'd13, 1'b0, 5'd0, '0, 1'b0, '0, '0, "rd13");
    idle("hold");

    // Sub-word merge into the full-written row.
    step(1'b0, 5'd0, 1'b1, 5'd12, '0, 1'b1, 32'd3, 32'hDEAD_BEEF, "sub12");
    step(1'b1, 5'd12, 1'b0, 5'd0, '0, 1'b0, '0, '0, "rd12m");

    // Write-first collision with a sub-word write.
    step(1'b1, 5'd20, 1'b1, 5'd20, '0, 1'b1, 32'd11, 32'h1234_5678, "coll20");
    // Read of a different row during a write returns old contents.
    step(1'b1, 5'd12, 1'b1, 5'd20, mk_row(32'h0BAD_0000), 1'b0, '0, '0, "indep");

    // Mid-stream asynchronous reset.
    do_reset();
    step(1'b1, 5'd12, 1'b0, 5'd0, '0, 1'b0, '0, '0, "rd12z");

    // Illegal lane index: dropped, sticky error.
    step(1'b0, 5'd0, 1'b1, 5'd4, mk_row(32'h4444_0000), 1'b0, '0, '0, "wr4");
    step(1'b0, 5'd0, 1'b1, 5'd4, '0, 1'b1, 32'd12, 32'hFFFF_FFFF, "bad4");
    step(1'b1, 5'd4, 1'b0, 5'd0, '0, 1'b0, '0, '0, "rd4");
    for (int i = 0; i < 10; i++)
      step(1'b0, 5'd0, 1'b1, 5'(i + 1), mk_row(32'(i) << 8), 1'b0, '0, '0, "legal");
    step(1'b0, 5'd0, 1'b0, 5'd4, '0, 1'b1, 32'd15, '0, "subnowr");
    do_reset();
    idle("posterr");

    // Throughput: write row i while reading row i-1 every cycle.
    for (int i = 0; i < 32; i++)
      step(1'b1, 5'(i - 1), 1'b1, 5'(i), mk_row(32'(i) << 16), 1'b0, '0, '0, "thru");

    // Randomized traffic including collisions and occasional illegal lanes.
    for (int n = 0; n < 400; n++) begin
      logic [383:0] wd;
      logic [31:0]  sa;
      for (int k = 0; k < 12; k++) wd[k*32 +: 32] = $urandom;
      sa = ($urandom_range(0, 19) == 0) ? 32'h8000_0000 | $urandom : 32'($urandom_range(0, 12));
      if ($urandom_range(0, 39) == 0 && n > 200) sa = 32'd13;
      step(1'($urandom), 5'($urandom_range(0, 31)), 1'($urandom),
           5'($urandom_range(0, 31)), wd, 1'($urandom), sa, $urandom, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
